// File: rtl/arm_pkg.sv
// Shared constants for the ARM-subset pipeline: datapath width, register count,
// PC alias address and status-register bit positions.
package arm_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 15;

    localparam logic [3:0] REG_PC = 4'd15;

    localparam int SR_N = 3;
    localparam int SR_Z = 2;
    localparam int SR_C = 1;
    localparam int SR_V = 0;

    typedef logic [3:0] reg_addr_t;
    typedef logic [3:0] status_t;

endpackage

// File: rtl/register_file_wb_if.sv
// ID/WB/EXE-facing signal bundle of the register file. The pipeline side is the
// master and the register file is the slave.
interface register_file_wb_if
    import arm_pkg::*;
#(
    parameter int DW = DATA_W
);
    reg_addr_t         src1;
    reg_addr_t         src2;
    logic [DW-1:0]     Val_Rn;
    logic [DW-1:0]     Val_Rm;
    logic              writeBackEn;
    reg_addr_t         Dest_wb;
    logic [DW-1:0]     Result_WB;
    logic [DW-1:0]     pc_id;
    logic              S_EXE;
    status_t           status_bits;
    logic              freeze;
    status_t           SR;
    logic [15:0]       wr_count;

    modport master (
        output src1, src2, writeBackEn, Dest_wb, Result_WB, pc_id,
               S_EXE, status_bits, freeze,
        input  Val_Rn, Val_Rm, SR, wr_count
    );

    modport slave (
        input  src1, src2, writeBackEn, Dest_wb, Result_WB, pc_id,
               S_EXE, status_bits, freeze,
        output Val_Rn, Val_Rm, SR, wr_count
    );
endinterface

// File: rtl/status_register.sv
// 4-bit {N,Z,C,V} holding register with load enable and async active-high reset.
// Shared with the EXE stage model.
module status_register
    import arm_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    en_i,
    input  status_t d_i,
    output status_t q_o
);
    status_t sr_q;
    status_t sr_d;

    assign sr_d = en_i ? d_i : sr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q_o = sr_q;
endmodule

// File: rtl/register_file_wb.sv
// Architectural register file R0..R14 with one write port, two bypassed combinational
// read ports, a PC alias at address 15, and the status register.
module register_file_wb #(
    parameter int NUM_REGS = arm_pkg::NUM_REGS,
    parameter int DATA_W   = arm_pkg::DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    register_file_wb_if.slave  bus
);
    import arm_pkg::*;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [15:0]       wr_count_q;
    logic [15:0]       wr_count_d;
    logic              wr_en;
    logic              sr_en;

    // Writes aimed at the PC alias are dropped and not counted.
    assign wr_en      = bus.writeBackEn && (bus.Dest_wb != REG_PC);
    assign wr_count_d = wr_en ? wr_count_q + 16'd1 : wr_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= DATA_W'(i);
            end
            wr_count_q <= '0;
        end else begin
            if (wr_en) begin
                regs_q[bus.Dest_wb] <= bus.Result_WB;
            end
            wr_count_q <= wr_count_d;
        end
    end

    // Bypass does not look at rst, so WB data is still forwarded while storage is held in reset.
    always_comb begin
        if (bus.src1 == REG_PC) begin
            bus.Val_Rn = bus.pc_id + DATA_W'(4);
        end else if (bus.writeBackEn && (bus.Dest_wb == bus.src1)) begin
            bus.Val_Rn = bus.Result_WB;
        end else begin
            bus.Val_Rn = regs_q[bus.src1];
        end
    end

    always_comb begin
        if (bus.src2 == REG_PC) begin
            bus.Val_Rm = bus.pc_id + DATA_W'(4);
        end else if (bus.writeBackEn && (bus.Dest_wb == bus.src2)) begin
            bus.Val_Rm = bus.Result_WB;
        end else begin
            bus.Val_Rm = regs_q[bus.src2];
        end
    end

    assign sr_en = bus.S_EXE && !bus.freeze;

    status_register u_status_register (
        .clk  (clk),
        .rst  (rst),
        .en_i (sr_en),
        .d_i  (bus.status_bits),
        .q_o  (bus.SR)
    );

    assign bus.wr_count = wr_count_q;
endmodule

// File: tb/tb_register_file_wb.sv
// Scoreboard bench for register_file_wb: directed cases plus random traffic, expected
// outputs from an array-based reference model, checked by a separate monitor.
module tb_register_file_wb;

    logic clk;
    logic rst;

    register_file_wb_if #(.DW(32)) bus ();

    register_file_wb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] rn;
        logic [31:0] rm;
        logic [3:0]  sr;
        logic [15:0] wc;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_r [15];
    logic [3:0]  m_sr;
    logic [15:0] m_wc;

    function automatic void model_reset();
        for (int i = 0; i < 15; i++) m_r[i] = 32'(i);
        m_sr = 4'd0;
        m_wc = 16'd0;
    endfunction

    function automatic logic [31:0] model_read(input logic [3:0] a);
        if (a == 4'd15) return bus.pc_id + 32'd4;
        if (bus.writeBackEn && bus.Dest_wb == a) return bus.Result_WB;
        return m_r[a];
    endfunction

    // One clock: expected values for the current inputs go to the scoreboard
    // (when chk is set), then the model advances with the edge.
    task automatic step(input string tag, input bit chk);
        exp_t e;
        if (rst) model_reset();
        if (chk) begin
            e.tag = tag;
            e.rn  = model_read(bus.src1);
            e.rm  = model_read(bus.src2);
            e.sr  = m_sr;
            e.wc  = m_wc;
            exp_q.push_back(e);
        end
        @(posedge clk);
        if (!rst) begin
            if (bus.writeBackEn && bus.Dest_wb != 4'd15) begin
                m_r[bus.Dest_wb] = bus.Result_WB;
                m_wc = m_wc + 16'd1;
            end
            if (bus.S_EXE && !bus.freeze) m_sr = bus.status_bits;
        end
        #1;
    endtask

    task automatic cmp(input string tag, input string field, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=%h required=%h", tag, field, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp(e.tag, "Val_Rn",   bus.Val_Rn,          e.rn);
                cmp(e.tag, "Val_Rm",   bus.Val_Rm,          e.rm);
                cmp(e.tag, "SR",       32'(bus.SR),         32'(e.sr));
                cmp(e.tag, "wr_count", 32'(bus.wr_count),   32'(e.wc));
            end
        end
    end

    task automatic idle_inputs();
        bus.writeBackEn = 1'b0;
        bus.Dest_wb     = 4'd0;
        bus.Result_WB   = 32'd0;
        bus.S_EXE       = 1'b0;
        bus.status_bits = 4'd0;
        bus.freeze      = 1'b0;
    endtask

    initial begin : stimulus
        rst      = 1'b1;
        bus.src1 = 4'd3;
        bus.src2 = 4'd14;
        bus.pc_id = 32'h0;
        idle_inputs();
        model_reset();
        @(posedge clk);
        #1;

        step("reset", 1'b1);
        rst = 1'b0;
        bus.src1 = 4'd0; bus.src2 = 4'd1;
        step("post_reset", 1'b1);

        bus.writeBackEn = 1'b1; bus.Dest_wb = 4'd5; bus.Result_WB = 32'hDEADBEEF;
        step("write_r5", 1'b1);
        idle_inputs();
        bus.src1 = 4'd5;
        step("read_r5", 1'b1);

        bus.writeBackEn = 1'b1; bus.Dest_wb = 4'd7; bus.Result_WB = 32'h1234;
        bus.src1 = 4'd7; bus.src2 = 4'd7;
        step("bypass_r7", 1'b1);
        idle_inputs();
        step("stored_r7", 1'b1);

        bus.src2 = 4'd15; bus.pc_id = 32'h20;
        step("pc_alias", 1'b1);
        bus.writeBackEn = 1'b1; bus.Dest_wb = 4'd15; bus.Result_WB = 32'hCAFEF00D;
        step("write_pc", 1'b1);
        idle_inputs();
        step("after_write_pc", 1'b1);

        bus.S_EXE = 1'b1; bus.status_bits = 4'b1010;
        step("sr_load", 1'b1);
        idle_inputs();
        step("sr_loaded", 1'b1);
        bus.S_EXE = 1'b1; bus.freeze = 1'b1; bus.status_bits = 4'b0101;
        bus.writeBackEn = 1'b1; bus.Dest_wb = 4'd9; bus.Result_WB = 32'h99;
        step("sr_frozen", 1'b1);
        idle_inputs();
        bus.src1 = 4'd9;
        step("sr_held", 1'b1);

        bus.writeBackEn = 1'b1; bus.Dest_wb = 4'd2; bus.Result_WB = 32'hFF;
        step("write_r2", 1'b1);
        idle_inputs();
        bus.src1 = 4'd2;
        rst = 1'b1;
        step("async_rst", 1'b1);
        bus.writeBackEn = 1'b1; bus.Dest_wb = 4'd4; bus.Result_WB = 32'hAAAA;
        bus.src2 = 4'd4;
        step("rst_bypass", 1'b1);
        rst = 1'b0;
        idle_inputs();
        step("rst_write_lost", 1'b1);

        for (int n = 0; n < 2000; n++) begin
            bus.src1        = 4'($urandom_range(0, 15));
            bus.src2        = ($urandom_range(0, 3) == 0) ? bus.src1 : 4'($urandom_range(0, 15));
            bus.writeBackEn = 1'($urandom);
            bus.Dest_wb     = ($urandom_range(0, 2) == 0) ? bus.src1 : 4'($urandom_range(0, 15));
            bus.Result_WB   = $urandom;
            bus.pc_id       = $urandom;
            bus.S_EXE       = 1'($urandom);
            bus.status_bits = 4'($urandom);
            bus.freeze      = ($urandom_range(0, 3) == 0);
            rst             = ($urandom_range(0, 99) == 0);
            step("random", 1'b1);
        end
        rst = 1'b0;

        rst = 1'b1;
        idle_inputs();
        step("wrap_reset", 1'b0);
        rst = 1'b0;
        bus.writeBackEn = 1'b1;
        for (int n = 0; n < 65535; n++) begin
            bus.Dest_wb   = 4'(n % 15);
            bus.Result_WB = 32'(n);
            step("fill", 1'b0);
        end
        bus.Dest_wb = 4'd15;
        step("wrap_ffff", 1'b1);
        bus.Dest_wb = 4'd3; bus.Result_WB = 32'h5A5A;
        step("wrap_last", 1'b1);
        idle_inputs();
        bus.src1 = 4'd3;
        step("wrap_zero", 1'b1);

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
